// File: rtl/accum_ctrl_pkg.sv
// Shared encodings for the operand/adder sequencing controller.
// State codes are also shown on the board LEDs.
package accum_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GOT_A = 2'b01,
    CALC  = 2'b10,
    SHOW  = 2'b11
  } state_t;

endpackage

// File: rtl/addsub_unit.sv
// Combinational add/subtract with carry and signed overflow.
// Subtract is a + ~b + 1, so cout=1 means no borrow.
module addsub_unit
  import accum_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   r;

  assign bx   = sub ? ~b : b;
  assign r    = {1'b0, a} + {1'b0, bx}
              + {{WIDTH{1'b0}}, sub};
  assign sum  = r[WIDTH-1:0];
  assign cout = r[WIDTH];
  assign ovf  = (a[WIDTH-1] == bx[WIDTH-1])
              && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/accum_ctrl.sv
// Captures A then B on ENTER presses, runs one add/sub,
// shows the result and chains it as the next A.
module accum_ctrl
  import accum_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             ENTER,
  input  logic [WIDTH-1:0] DATA,
  input  logic             SUB,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF,
  output logic             DONE,
  output logic [1:0]       STATE
);

  state_t           state;
  logic             enter_d;
  logic             op;
  logic             cmd;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  assign cmd   = ENTER & ~enter_d;
  assign STATE = state;

  addsub_unit #(.WIDTH(WIDTH)) u_addsub (
    .a    (A),
    .b    (B),
    .sub  (op),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  // enter_d resets high so a key held through reset must be re-pressed
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state   <= IDLE;
      enter_d <= 1'b1;
      op      <= 1'b0;
      A       <= '0;
      B       <= '0;
      S       <= '0;
      COUT    <= 1'b0;
      OVF     <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      enter_d <= ENTER;
      DONE    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd) begin
            A     <= DATA;
            state <= GOT_A;
          end
        end
        GOT_A: begin
          if (cmd) begin
            B     <= DATA;
            op    <= SUB;
            state <= CALC;
          end
        end
        CALC: begin
          S     <= sum;
          COUT  <= cout;
          OVF   <= ovf;
          DONE  <= 1'b1;
          state <= SHOW;
        end
        SHOW: begin
          if (cmd) begin
            A     <= S;
            B     <= DATA;
            op    <= SUB;
            state <= CALC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/accum_ctrl.md
# accum_ctrl

Sequencing controller for the 8-bit operand/adder datapath on the lab board. It captures operand A and then operand B from the switches on successive ENTER presses and runs one add or subtract per operation. It then holds the result for display and chains it as the next A for running accumulation. It sits between the debounced key/switch inputs and the hex display decoders, and it owns the only adder instance.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge
- RESET  in  1  reset, synchronous and active-high
- ENTER  in  1  level, active-high, already debounced; each rising edge is one command
- DATA  in  WIDTH  operand value from switches; sampled on a command
- SUB  in  1  0 = A+B, 1 = A−B; sampled together with B
- A  out  WIDTH  registered operand A
- B  out  WIDTH  registered operand B
- S  out  WIDTH  registered result
- COUT  out  1  registered carry out; for subtract, 1 = no borrow
- OVF  out  1  registered two's-complement overflow
- DONE  out  1  one-cycle pulse when S/COUT/OVF update
- STATE  out  2  current FSM state, for LED display

## Operation
- Command detection: an internal register ENTER_d follows ENTER each cycle. A command is asserted when ENTER=1 and ENTER_d=0. Only one command fires per press.
- FSM states (encoding): IDLE=00, GOT_A=01, CALC=10, SHOW=11.
- IDLE: on a command, A<=DATA and the FSM moves to GOT_A.
- GOT_A: on a command, B<=DATA, op<=SUB, and the FSM moves to CALC.
- CALC: lasts exactly one cycle with no condition. {COUT,S} and OVF are registered from the adder. DONE=1 and the FSM moves to SHOW.
- SHOW: A, B and S hold. On a command, A<=S, B<=DATA, op<=SUB, and the FSM moves to CALC. This chains the result as the next A.
- Arithmetic:
  - Add: {COUT,S} = A + B, computed at WIDTH+1 bits.
  - Subtract: {COUT,S} = A + ~B + 1.
  - OVF = (A[msb] == B'[msb]) && (S[msb] != A[msb]), where B' is the effective second operand (B or ~B).
  - Results wrap modulo 2^WIDTH.
- A command in CALC is ignored and dropped. ENTER_d still updates.
- DATA and SUB have no effect outside a command.

## Timing
- Reset values: A=0, B=0, S=0, COUT=0, OVF=0, DONE=0, STATE=IDLE, op=0.
- ENTER_d resets to 1. A key held through reset deassertion therefore does not fire; it must be released and pressed again.
- RESET has priority over every transition. Reset asserted during CALC produces no DONE and leaves all outputs at their reset values on the next edge.
- Latency, with ENTER first sampled high at edge k while in GOT_A or SHOW:
  - Edge k: B, op (and A in SHOW) capture; STATE=CALC after k.
  - Edge k+1: S/COUT/OVF valid; DONE=1 for the cycle after k+1; STATE=SHOW.
  - Total: 2 edges from command to result.
- Latency in IDLE: A captures at edge k.
- DONE is high for exactly one cycle per CALC and is never back-to-back.
- The adder output is combinational from A/B/op. Only its registered copy is visible at the ports.

## Structure
- Shared package/header holds the state encodings (IDLE, GOT_A, CALC, SHOW) and the default WIDTH.
- Sub-module addsub_unit: purely combinational WIDTH-bit adder with inputs a, b, sub and outputs sum, cout, ovf. It is instantiated once in accum_ctrl and is reusable by other labs.
- Hex display decoding stays outside this block.

## Test plan
- Reset: hold RESET 2 cycles with random DATA/ENTER -> A=B=S=0, COUT=OVF=DONE=0, STATE=00.
- Basic add: press with DATA=0x3C, then press with DATA=0x14 and SUB=0 -> A=0x3C, B=0x14, S=0x50, COUT=0, OVF=0. DONE pulses exactly once, 2 edges after the second press. STATE ends at 11.
- Carry/overflow:
  - 0xFF+0x01 -> S=0x00, COUT=1, OVF=0.
  - 0x7F+0x01 -> S=0x80, COUT=0, OVF=1.
- Subtract: 0x10 − 0x20 (SUB=1) -> S=0xF0, COUT=0, OVF=0. Then 0x80 − 0x01 -> S=0x7F, OVF=1.
- Chaining: from SHOW with S=0x50, press with DATA=0x05 and SUB=1 -> A=0x50, B=0x05, S=0x4B, DONE once. A held ENTER (10+ cycles) yields only one command.
- Reset corner cases:
  - ENTER held high across reset release -> no capture until ENTER goes low then high.
  - RESET asserted in the CALC cycle -> no DONE, all outputs zero, STATE=IDLE.
